// File: rtl/tts_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package tts_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Widest supported sweep: 8 inputs -> 256 table bits.
  localparam int MAX_N_IN = 8;
  localparam int MAX_NVEC = 1 << MAX_N_IN;
  localparam int DEF_N_IN = 4;
  localparam int NVEC     = 1 << DEF_N_IN;

  // Number of set bits in a (zero-extended) truth-table difference.
  function automatic logic [8:0] popcount(input logic [MAX_NVEC-1:0] v);
    logic [8:0] c;
    c = 9'd0;
    for (int i = 0; i < MAX_NVEC; i++) begin
      c = c + {8'd0, v[i]};
    end
    return c;
  endfunction

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [7:0] first_one(input logic [MAX_NVEC-1:0] v);
    logic [7:0] idx;
    idx = 8'd0;
    for (int i = MAX_NVEC - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = i[7:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Dwell counter: counts 0..DWELL-1 while enabled and flags the sample and
// final cycle of each window.
module dwell_counter #(
  parameter int DWELL      = 20,
  parameter int SAMPLE_OFS = DWELL - 1,
  localparam int CW        = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          sample,
  output logic          last
);

  localparam logic [CW-1:0] LAST_V = CW'(DWELL - 1);
  localparam logic [CW-1:0] SOFS_V = CW'(SAMPLE_OFS);
  localparam logic [CW-1:0] ONE_V  = CW'(1);

  logic [CW-1:0] count_r;

  // Count through the dwell window, wrapping after the last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en) begin
      if (count_r == LAST_V) begin
        count_r <= '0;
      end else begin
        count_r <= count_r + ONE_V;
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign count  = count_r;
  assign sample = en & (count_r == SOFS_V);
  assign last   = en & (count_r == LAST_V);

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: drives every input vector in order, captures
// the single-bit response into a truth table and compares it to an expectation.
module truth_table_sweeper
  import tts_pkg::*;
#(
  parameter int  N_IN       = 4,
  parameter int  DWELL      = 20,
  parameter int  SAMPLE_OFS = DWELL - 1,
  localparam int NV         = 1 << N_IN,
  localparam int CW         = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [NV-1:0]   exp_tt,
  input  logic            dut_f,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic [NV-1:0]   tt,
  output logic            match,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_err
);

  localparam logic [N_IN-1:0] STIM_MAX = N_IN'(NV - 1);
  localparam logic [N_IN-1:0] STIM_ONE = N_IN'(1);

  state_t state_r, state_nx;

  logic            accept_s, abort_s, cnt_en_s, cnt_clr_s, finish_s;
  logic            smp_s, lst_s, sample_s, step_s;
  logic [CW-1:0]   dwell_cnt_unused_s;
  logic [MAX_NVEC-1:0] diff_s;

  logic [NV-1:0]   exp_r, tt_r;
  logic [N_IN-1:0] stim_r, first_err_r;
  logic [N_IN:0]   err_cnt_r;
  logic            busy_r, done_r, match_r;

  dwell_counter #(
    .DWELL      (DWELL),
    .SAMPLE_OFS (SAMPLE_OFS)
  ) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr_s),
    .en     (cnt_en_s),
    .count  (dwell_cnt_unused_s),
    .sample (smp_s),
    .last   (lst_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state selection; abort overrides every sweep transition.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (start && !abort) state_nx = DRIVE;
        else                 state_nx = IDLE;
      end
      DRIVE: begin
        if (abort)                           state_nx = IDLE;
        else if (lst_s && stim_r == STIM_MAX) state_nx = CHECK;
        else                                 state_nx = DRIVE;
      end
      CHECK: begin
        if (abort) state_nx = IDLE;
        else       state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Per-state control strobes for the counter and datapath.
  always_comb begin
    accept_s = 1'b0;
    abort_s  = 1'b0;
    cnt_en_s = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      IDLE: begin
        accept_s = start & ~abort;
      end
      DRIVE: begin
        abort_s  = abort;
        cnt_en_s = ~abort;
      end
      CHECK: begin
        abort_s  = abort;
        finish_s = ~abort;
      end
      DONE: begin
        accept_s = 1'b0;
      end
      default: begin
        accept_s = 1'b0;
      end
    endcase
  end

  assign cnt_clr_s = accept_s | abort_s;
  assign sample_s  = cnt_en_s & smp_s;
  assign step_s    = cnt_en_s & lst_s & (stim_r != STIM_MAX);
  assign diff_s    = MAX_NVEC'(tt_r ^ exp_r);

  // Registered datapath: stimulus, capture table and comparison results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_r       <= '0;
      tt_r        <= '0;
      stim_r      <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      match_r     <= 1'b0;
      err_cnt_r   <= '0;
      first_err_r <= '0;
    end else begin
      done_r <= finish_s;
      if (accept_s) begin
        exp_r       <= exp_tt;
        tt_r        <= '0;
        stim_r      <= '0;
        busy_r      <= 1'b1;
        match_r     <= 1'b0;
        err_cnt_r   <= '0;
        first_err_r <= '0;
      end else if (abort_s) begin
        stim_r      <= '0;
        busy_r      <= 1'b0;
        match_r     <= 1'b0;
        err_cnt_r   <= '0;
        first_err_r <= '0;
      end else if (finish_s) begin
        stim_r      <= '0;
        busy_r      <= 1'b0;
        match_r     <= (diff_s == '0);
        err_cnt_r   <= (N_IN + 1)'(popcount(diff_s));
        first_err_r <= N_IN'(first_one(diff_s));
      end else begin
        if (sample_s) tt_r[stim_r] <= dut_f;
        else          tt_r <= tt_r;
        if (step_s)   stim_r <= stim_r + STIM_ONE;
        else          stim_r <= stim_r;
      end
    end
  end

  assign stim      = stim_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign tt        = tt_r;
  assign match     = match_r;
  assign err_cnt   = err_cnt_r;
  assign first_err = first_err_r;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: table-driven full sweeps plus
// abort, reset, start-while-busy and a small-parameter instance.
module tb_truth_table_sweeper;

  logic        clk;
  logic        rst_n;
  logic        start, abort;
  logic [15:0] exp_tt;
  logic        dut_f;
  logic [3:0]  stim;
  logic        busy, done, match;
  logic [15:0] tt;
  logic [4:0]  err_cnt;
  logic [3:0]  first_err;
  int          mode;

  logic        start_s;
  logic [3:0]  exp_tt_s;
  logic        dut_f_s;
  logic [1:0]  stim_s;
  logic        busy_s, done_s, match_s;
  logic [3:0]  tt_s;
  logic [2:0]  err_cnt_s;
  logic [1:0]  first_err_s;

  int pass_cnt  = 0;
  int total_cnt = 0;

  truth_table_sweeper #(.N_IN(4), .DWELL(20)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .exp_tt(exp_tt),
    .dut_f(dut_f), .stim(stim), .busy(busy), .done(done), .tt(tt),
    .match(match), .err_cnt(err_cnt), .first_err(first_err)
  );

  truth_table_sweeper #(.N_IN(2), .DWELL(2)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .abort(1'b0), .exp_tt(exp_tt_s),
    .dut_f(dut_f_s), .stim(stim_s), .busy(busy_s), .done(done_s), .tt(tt_s),
    .match(match_s), .err_cnt(err_cnt_s), .first_err(first_err_s)
  );

  // Modelled lab DUTs: 4-input parity or a&b; 2-input xor for the small one.
  assign dut_f   = (mode == 0) ? ^stim : (stim[3] & stim[2]);
  assign dut_f_s = stim_s[1] ^ stim_s[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] exp_v;
    int          md;
    logic [15:0] tt_v;
    logic        m_v;
    logic [4:0]  ec_v;
    logic [3:0]  fe_v;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  // Full sweep on the 4-input instance; optionally pulses start mid-sweep.
  task automatic run_sweep(input logic [15:0] e, input int md, input bit poke, output int lat);
    int stim_bad;
    stim_bad = 0;
    mode   = md;
    exp_tt = e;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    while (!done && lat < 400) begin
      if (lat <= 320 && stim != 4'((lat - 1) / 20)) stim_bad++;
      if (poke && lat == 50) begin
        start  = 1'b1;
        exp_tt = ~e;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("stim_sequence", stim_bad, 32'd0);
  endtask

  initial begin
    int lat;
    int done_seen;

    vecs[0] = '{16'h6996, 0, 16'h6996, 1'b1, 5'd0,  4'd0};
    vecs[1] = '{16'h6997, 0, 16'h6996, 1'b0, 5'd1,  4'd0};
    vecs[2] = '{16'h0000, 1, 16'hF000, 1'b0, 5'd4,  4'd12};
    vecs[3] = '{16'hFFFF, 1, 16'hF000, 1'b0, 5'd12, 4'd0};
    vecs[4] = '{16'hF000, 1, 16'hF000, 1'b1, 5'd0,  4'd0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; exp_tt = 16'h0; mode = 0;
    start_s = 1'b0; exp_tt_s = 4'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst_stim", {28'd0, stim}, 32'd0);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check("rst_tt", {16'd0, tt}, 32'd0);
    check("rst_results", {22'd0, match, err_cnt, first_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Asynchronous reset in the middle of a sweep.
    mode = 0; exp_tt = 16'h6996; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_stim", {28'd0, stim}, 32'd0);
    check("midrst_busy_done", {30'd0, busy, done}, 32'd0);
    check("midrst_tt", {16'd0, tt}, 32'd0);
    check("midrst_results", {22'd0, match, err_cnt, first_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of full sweeps; entry 0 also pulses start while busy.
    for (int i = 0; i < 5; i++) begin
      run_sweep(vecs[i].exp_v, vecs[i].md, (i == 0), lat);
      check("latency", lat, 32'd322);
      check("tt", {16'd0, tt}, {16'd0, vecs[i].tt_v});
      check("match", {31'd0, match}, {31'd0, vecs[i].m_v});
      check("err_cnt", {27'd0, err_cnt}, {27'd0, vecs[i].ec_v});
      check("first_err", {28'd0, first_err}, {28'd0, vecs[i].fe_v});
      check("done_busy_stim", {27'd0, busy, stim}, 32'd0);
      @(negedge clk);
      check("done_pulse_width", {31'd0, done}, 32'd0);
      check("results_hold", {22'd0, match, err_cnt, first_err},
            {22'd0, vecs[i].m_v, vecs[i].ec_v, vecs[i].fe_v});
    end

    // Abort while stim == 7 (dwell count 5): partial table, no done.
    mode = 0; exp_tt = 16'h6996; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (145) @(negedge clk);
    check("abort_pre_stim", {28'd0, stim}, 32'd7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy_stim", {27'd0, busy, stim}, 32'd0);
    check("abort_tt", {16'd0, tt}, 32'h0016);
    check("abort_results", {22'd0, match, err_cnt, first_err}, 32'd0);
    done_seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    check("abort_no_done", done_seen, 32'd0);

    // start and abort together in IDLE: nothing starts.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", {31'd0, busy}, 32'd0);
    repeat (25) @(negedge clk);
    check("start_abort_stim_tt", {12'd0, stim, tt}, 32'h0016);

    // Small instance: 2 inputs, dwell 2 -> done 10 cycles after acceptance.
    exp_tt_s = 4'b0110; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    lat = 1;
    while (!done_s && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("small_latency", lat, 32'd10);
    check("small_tt", {28'd0, tt_s}, 32'h6);
    check("small_match", {26'd0, match_s, err_cnt_s, first_err_s}, {26'd0, 1'b1, 3'd0, 2'd0});
    @(negedge clk);
    exp_tt_s = 4'b0100; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    lat = 1;
    while (!done_s && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("small_latency2", lat, 32'd10);
    check("small_mismatch", {26'd0, match_s, err_cnt_s, first_err_s}, {26'd0, 1'b0, 3'd1, 2'd1});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Hardware exhaustive-stimulus engine for small combinational blocks in the lab designs. On `start` it drives every input combination 0..2^N_IN-1 in ascending binary order. It holds each vector for a programmable dwell, samples the DUT's single-bit response and builds the full truth table. At the end it compares the table against an expected table and reports a match flag, a mismatch count and the first failing index; this is the synthesizable successor to the fixed 4-input, 20-step bench sweep.

Parameters:
N_IN, 4, number of DUT inputs; sweep length 2^N_IN vectors (legal 1..8)
DWELL, 20, clock cycles each vector is held (legal >= 2)
SAMPLE_OFS, DWELL-1, cycle within the dwell window at which dut_f is sampled (0..DWELL-1)

Ports:
clk  in  1  system clock, rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin sweep; accepted only in IDLE, one-cycle pulse or level
abort  in  1  terminate sweep, return to IDLE without done
exp_tt  in  2^N_IN  expected truth table, bit i = expected f for vector i; sampled at start
dut_f  in  1  DUT response
stim  out  N_IN  vector driven to DUT; stim[N_IN-1] is the MSB input ("a")
busy  out  1  high from the cycle after start acceptance until done or abort
done  out  1  one-cycle pulse when the sweep completes
tt  out  2^N_IN  captured truth table; bit i = dut_f sampled at vector i
match  out  1  tt == exp_tt; valid from done, held until next start
err_cnt  out  N_IN+1  number of mismatching bits
first_err  out  N_IN  lowest failing index; 0 when err_cnt==0

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; stim=0, busy=0, done=0, tt=0, match=0, err_cnt=0, first_err=0; dwell counter=0.
- States: IDLE, DRIVE, CHECK, DONE.
- IDLE: start=1 latches exp_tt, clears tt/err_cnt/first_err/match, sets stim=0 and dwell=0, and goes to DRIVE. start in any other state is ignored.
- DRIVE: stim is stable for exactly DWELL cycles. The dwell counter runs 0..DWELL-1. When the counter equals SAMPLE_OFS, tt[stim] <= dut_f.
  - At counter==DWELL-1 with stim != 2^N_IN-1: stim increments and the counter resets.
  - At counter==DWELL-1 with stim == 2^N_IN-1: go to CHECK. stim holds its last value and does not wrap.
- CHECK (1 cycle): compute diff = tt ^ exp_tt; err_cnt = popcount(diff); first_err = index of lowest set bit; match = (diff==0). Go to DONE.
- DONE (1 cycle): done=1, busy drops to 0 in the same cycle, stim returns to 0. Go to IDLE.
- Total latency from start acceptance to done: 2^N_IN*DWELL + 2 cycles.
- abort: takes priority over every transition in DRIVE/CHECK. Next state is IDLE, busy=0, no done pulse, stim=0. tt keeps partial contents; match/err_cnt/first_err are cleared.
- start and abort both asserted in IDLE: abort wins and the sweep does not start.
- Reset mid-sweep: immediate return to reset values; no done pulse.
- Results (tt, match, err_cnt, first_err) hold their values in IDLE until the next accepted start.

Decomposition:
- Package tts_pkg: state enum (IDLE, DRIVE, CHECK, DONE), localparam NVEC = 1<<N_IN, and a popcount/first-one function pair.
- Sub-module dwell_counter (parametrised on DWELL): provides the count, a `sample` strobe and a `last` strobe, with a synchronous clear input.

Test Plan:
- N_IN=4, DWELL=20, DUT model f = a^b^c^d, exp_tt=16'h6996, start pulse -> stim steps 0..15, each held 20 cycles; done at cycle 322 after acceptance; tt=16'h6996, match=1, err_cnt=0, first_err=0.
- Same DUT, exp_tt=16'h6997 -> tt=16'h6996, match=0, err_cnt=1, first_err=0.
- DUT f = a&b (stim[3]&stim[2]), exp_tt=16'h0000 -> tt=16'hF000, err_cnt=4, first_err=12.
- Assert abort while stim=7 -> next cycle busy=0, stim=0, no done pulse; tt[6:0] populated; err_cnt=0.
- Drop rst_n asynchronously during DRIVE -> all outputs read reset values before the next clock edge; a new start afterwards produces a full correct sweep.
- Assert start while busy -> ignored, sweep timing unchanged. Separately, run with N_IN=2, DWELL=2 -> done after 10 cycles, tt width 4.
